dp_timing_ctrl: RTL and testbench
=================================

Name: dp_timing_ctrl

Overview:
Register-programmable controller that configures and sequences the DisplayPort test-pattern timing generator. Software writes staged timing through a simple register port, then commits it. The controller validates the values and swaps them into the generator only at a frame boundary. It pulses the generator's RESET so every timing change starts on a clean frame, and it reports status and a frame count.

Parameters:
RESET_CYCLES, 4, cycles GEN_RESET is held high when new timing is applied (min 1)
DEF_WIDTH, 2200, reset value of staged/active WIDTH
DEF_HEIGHT, 1125, reset value of staged/active HEIGHT

Ports:
CLK  in  1  single clock for the block and the generator
RST_N  in  1  synchronous active-low reset
WR_EN  in  1  register write strobe, one cycle per write
WR_ADDR, RD_ADDR  in  3  register address
WR_DATA  in  32  write data
RD_EN  in  1  register read strobe
RD_DATA  out  32  read data, valid the cycle after RD_EN
VSYNC_IN  in  1  VSYNC output of the generator, same clock domain
GEN_RESET  out  1  drives the generator RESET
WIDTH, HEIGHT  out  16 each  active total width and height
HSYNC_START, HSYNC_END, VSYNC_START, VSYNC_END  out  16 each  active sync windows
ACTIVE_H_START, ACTIVE_W_START  out  16 each  active blanking offsets
BURST_LEN, WAIT  out  8 each  active pixel burst and gap
BUSY  out  1  high when a commit is pending or being applied

Behaviour:
- Register map (32-bit):
  - 0 CTRL: [0] ENABLE (R/W); [1] COMMIT (W1, self-clearing, reads 0); [2] ERR_CLR (W1, reads 0).
  - 1 {HEIGHT, WIDTH}.
  - 2 {HSYNC_END, HSYNC_START}.
  - 3 {VSYNC_END, VSYNC_START}.
  - 4 {ACTIVE_H_START, ACTIVE_W_START}.
  - 5 {16'h0, WAIT, BURST_LEN}.
  - 6 STATUS (RO): [1:0] state, [2] pending, [3] ERR.
  - 7 FRAME_COUNT (RO).
- Addresses 1–5 write the staged (shadow) set only. Reads of 1–5 return the staged set. Writes to 6 and 7 are ignored.
- Reset state:
  - Staged and active sets: WIDTH=DEF_WIDTH, HEIGHT=DEF_HEIGHT, BURST_LEN=1, all other fields 0.
  - ENABLE=0, ERR=0, pending=0, FRAME_COUNT=0, RD_DATA=0, state OFF, GEN_RESET=1, BUSY=0.
- Commit validation: the staged set is valid iff all of the following hold. On an invalid commit, ERR is set (sticky), nothing is applied, and pending is left unchanged.
  - WIDTH>=2 and HEIGHT>=2
  - ACTIVE_W_START<WIDTH and ACTIVE_H_START<HEIGHT
  - BURST_LEN!=0
  - HSYNC_START<=HSYNC_END and VSYNC_START<=VSYNC_END
- Frame boundary: rising edge of VSYNC_IN, detected against a 1-cycle registered copy.
- FSM transitions:
  - OFF(0): GEN_RESET=1. A valid COMMIT copies staged to active on the next cycle and does not set pending. ENABLE=1 goes to ARM.
  - ARM(1): on entry, copy staged to active if pending, then clear pending. Hold GEN_RESET=1 for exactly RESET_CYCLES cycles, then go to RUN. BUSY=1.
  - RUN(2): GEN_RESET=0. A valid COMMIT sets pending and goes to WAIT_FRAME.
  - WAIT_FRAME(3): GEN_RESET=0, BUSY=1. On a frame boundary, go to ARM. The copy uses the staged values current at that moment, so writes made while waiting are included.
- ENABLE=0 from any state goes to OFF on the next cycle. GEN_RESET=1 that cycle, and pending is cleared.
- COMMIT while already pending: no change, no error.
- Single-write CTRL rules:
  - Writing ENABLE 0→1 with COMMIT set in the same write: the commit is treated as pending, then OFF→ARM applies it.
  - ERR_CLR and COMMIT in the same write: ERR is cleared first, then validation may set it again.
- Active outputs change only while GEN_RESET=1, either in ARM or in OFF.
- FRAME_COUNT increments on each frame boundary in RUN or WAIT_FRAME and wraps at 2^32-1→0. It is cleared only by reset.
- RD_DATA: registered 1-cycle latency, holds its last value when RD_EN=0. A simultaneous write and read of the same address returns the old value.
- RST_N low mid-operation returns everything to reset values on that clock edge.

Decomposition:
- Package dp_timing_pkg holds:
  - register address constants
  - CTRL/STATUS bit indices
  - FSM state encoding (OFF=0, ARM=1, RUN=2, WAIT_FRAME=3)
  - a timing-set struct/typedef: field widths and packed layout
- Optional sub-module dp_timing_regs holds the staged set, read mux and validation. The FSM and active set stay in the top module.

Test Plan:
- After reset, read all registers: WIDTH=2200, HEIGHT=1125, BURST_LEN=1, STATUS=0, GEN_RESET=1.
- Write {HEIGHT=525, WIDTH=800}, then CTRL=3 (enable+commit) -> WIDTH=800 and HEIGHT=525 appear with GEN_RESET high for exactly 4 cycles, then GEN_RESET=0 and state RUN.
- In RUN, write WIDTH=1000, then COMMIT -> outputs unchanged and BUSY=1 until the next VSYNC_IN rise. Then 4 cycles of GEN_RESET with WIDTH=1000, then BUSY=0.
- Commit with ACTIVE_W_START=WIDTH -> ERR=1, active set unchanged, state unchanged. Write ERR_CLR -> ERR=0.
- Clear ENABLE while in WAIT_FRAME -> OFF next cycle, GEN_RESET=1, pending=0.
- Pulse VSYNC_IN 3 times in RUN -> FRAME_COUNT=3. Preload the count near 2^32-1 via a forced pulse sequence -> confirm wrap to 0.

Source files
------------

// File: rtl/dp_timing_pkg.sv
// Shared definitions for the DisplayPort timing controller: register map, CTRL/STATUS bits,
// FSM encoding and the packed timing set with its validation rule.
package dp_timing_pkg;

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrSize   = 3'd1;
    localparam logic [2:0] AddrHsync  = 3'd2;
    localparam logic [2:0] AddrVsync  = 3'd3;
    localparam logic [2:0] AddrActive = 3'd4;
    localparam logic [2:0] AddrBurst  = 3'd5;
    localparam logic [2:0] AddrStatus = 3'd6;
    localparam logic [2:0] AddrFrame  = 3'd7;

    localparam int unsigned CtrlEnable  = 0;
    localparam int unsigned CtrlCommit  = 1;
    localparam int unsigned CtrlErrClr  = 2;
    localparam int unsigned StatPending = 2;
    localparam int unsigned StatErr     = 3;

    typedef enum logic [1:0] {
        StOff       = 2'd0,
        StArm       = 2'd1,
        StRun       = 2'd2,
        StWaitFrame = 2'd3
    } state_e;

    typedef struct packed {
        logic [15:0] height;
        logic [15:0] width;
        logic [15:0] hsync_end;
        logic [15:0] hsync_start;
        logic [15:0] vsync_end;
        logic [15:0] vsync_start;
        logic [15:0] active_h_start;
        logic [15:0] active_w_start;
        logic [7:0]  wait_len;
        logic [7:0]  burst_len;
    } timing_t;

    function automatic timing_t timing_default(logic [15:0] w, logic [15:0] h);
        timing_t t;
        t           = '0;
        t.width     = w;
        t.height    = h;
        t.burst_len = 8'd1;
        return t;
    endfunction

    function automatic logic timing_valid(timing_t t);
        return (t.width >= 16'd2) && (t.height >= 16'd2) &&
               (t.active_w_start < t.width) && (t.active_h_start < t.height) &&
               (t.burst_len != 8'd0) &&
               (t.hsync_start <= t.hsync_end) && (t.vsync_start <= t.vsync_end);
    endfunction

endpackage

// File: rtl/dp_timing_ctrl_if.sv
// Software register port of the timing controller: write strobe, read strobe, registered read.
interface dp_timing_ctrl_if;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/dp_timing_regs.sv
// Register file: staged timing set, CTRL enable/ERR bits, commit validation and the read mux.
module dp_timing_regs
    import dp_timing_pkg::*;
#(
    parameter logic [15:0] DefWidth  = 16'd2200,
    parameter logic [15:0] DefHeight = 16'd1125
) (
    input  logic            clk,
    input  logic            rst_n,
    dp_timing_ctrl_if.slave bus,
    input  state_e          state,
    input  logic            pending,
    input  logic [31:0]     frame_count,
    output timing_t         staged,
    output logic            enable_nxt,
    output logic            commit_ok
);
    timing_t     staged_q;
    logic        enable_q, err_q, err_d;
    logic        ctrl_wr, commit_req, staged_ok;
    logic [31:0] rd_word, rd_data_q;

    assign ctrl_wr    = bus.wr_en && (bus.wr_addr == AddrCtrl);
    assign commit_req = ctrl_wr && bus.wr_data[CtrlCommit];
    assign staged_ok  = timing_valid(staged_q);
    assign commit_ok  = commit_req && staged_ok;
    assign enable_nxt = ctrl_wr ? bus.wr_data[CtrlEnable] : enable_q;
    // Clear is applied before the commit check so a combined write can re-raise ERR.
    assign err_d = (err_q && !(ctrl_wr && bus.wr_data[CtrlErrClr])) ||
                   (commit_req && !staged_ok && !pending);

    always_comb begin
        rd_word = '0;
        case (bus.rd_addr)
            AddrCtrl:   rd_word[CtrlEnable] = enable_q;
            AddrSize:   rd_word = {staged_q.height, staged_q.width};
            AddrHsync:  rd_word = {staged_q.hsync_end, staged_q.hsync_start};
            AddrVsync:  rd_word = {staged_q.vsync_end, staged_q.vsync_start};
            AddrActive: rd_word = {staged_q.active_h_start, staged_q.active_w_start};
            AddrBurst:  rd_word = {16'h0, staged_q.wait_len, staged_q.burst_len};
            AddrStatus: rd_word = {28'h0, err_q, pending, state};
            AddrFrame:  rd_word = frame_count;
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            staged_q  <= timing_default(DefWidth, DefHeight);
            enable_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            enable_q <= enable_nxt;
            err_q    <= err_d;
            if (bus.rd_en) rd_data_q <= rd_word;
            if (bus.wr_en) begin
                case (bus.wr_addr)
                    AddrSize:   {staged_q.height, staged_q.width} <= bus.wr_data;
                    AddrHsync:  {staged_q.hsync_end, staged_q.hsync_start} <= bus.wr_data;
                    AddrVsync:  {staged_q.vsync_end, staged_q.vsync_start} <= bus.wr_data;
                    AddrActive: {staged_q.active_h_start, staged_q.active_w_start} <= bus.wr_data;
                    AddrBurst:  {staged_q.wait_len, staged_q.burst_len} <= bus.wr_data[15:0];
                    default:    ;
                endcase
            end
        end
    end

    assign staged      = staged_q;
    assign bus.rd_data = rd_data_q;
endmodule

// File: rtl/dp_timing_ctrl.sv
// Timing-generator sequencer: swaps committed timing into the active set at frame boundaries,
// holding the generator in reset while it changes, and counts frames.
module dp_timing_ctrl
    import dp_timing_pkg::*;
#(
    parameter int unsigned ResetCycles = 4,
    parameter logic [15:0] DefWidth    = 16'd2200,
    parameter logic [15:0] DefHeight   = 16'd1125
) (
    input  logic            clk,
    input  logic            rst_n,
    dp_timing_ctrl_if.slave bus,
    input  logic            vsync_in,
    output logic            gen_reset,
    output logic [15:0]     width,
    output logic [15:0]     height,
    output logic [15:0]     hsync_start,
    output logic [15:0]     hsync_end,
    output logic [15:0]     vsync_start,
    output logic [15:0]     vsync_end,
    output logic [15:0]     active_h_start,
    output logic [15:0]     active_w_start,
    output logic [7:0]      burst_len,
    output logic [7:0]      wait_len,
    output logic            busy
);
    localparam int unsigned CntW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
    localparam logic [CntW-1:0] ArmLast = CntW'(ResetCycles - 1);

    state_e          state_q;
    timing_t         active_q, staged;
    logic            pending_q, gen_reset_q, vsync_q, frame_rise;
    logic            enable_nxt, commit_ok;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     frame_count_q;

    dp_timing_regs #(
        .DefWidth  (DefWidth),
        .DefHeight (DefHeight)
    ) u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .state       (state_q),
        .pending     (pending_q),
        .frame_count (frame_count_q),
        .staged      (staged),
        .enable_nxt  (enable_nxt),
        .commit_ok   (commit_ok)
    );

    assign frame_rise = vsync_in && !vsync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StOff;
            pending_q     <= 1'b0;
            gen_reset_q   <= 1'b1;
            cnt_q         <= '0;
            vsync_q       <= 1'b0;
            frame_count_q <= '0;
            active_q      <= timing_default(DefWidth, DefHeight);
        end else begin
            vsync_q <= vsync_in;
            if (frame_rise && (state_q == StRun || state_q == StWaitFrame)) begin
                frame_count_q <= frame_count_q + 32'd1;
            end
            if (!enable_nxt) begin
                state_q     <= StOff;
                pending_q   <= 1'b0;
                gen_reset_q <= 1'b1;
                if (state_q == StOff && commit_ok) active_q <= staged;
            end else begin
                unique case (state_q)
                    StOff: begin
                        // A commit written together with ENABLE is applied on the way into ARM.
                        state_q     <= StArm;
                        gen_reset_q <= 1'b1;
                        cnt_q       <= ArmLast;
                        pending_q   <= 1'b0;
                        if (commit_ok) active_q <= staged;
                    end
                    StArm: begin
                        if (commit_ok) pending_q <= 1'b1;
                        if (cnt_q == '0) begin
                            state_q     <= (pending_q || commit_ok) ? StWaitFrame : StRun;
                            gen_reset_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    StRun: begin
                        if (commit_ok) begin
                            pending_q <= 1'b1;
                            state_q   <= StWaitFrame;
                        end
                    end
                    StWaitFrame: begin
                        if (frame_rise) begin
                            state_q     <= StArm;
                            gen_reset_q <= 1'b1;
                            cnt_q       <= ArmLast;
                            pending_q   <= 1'b0;
                            active_q    <= staged;
                        end
                    end
                endcase
            end
        end
    end

    assign gen_reset      = gen_reset_q;
    assign busy           = pending_q || (state_q == StArm) || (state_q == StWaitFrame);
    assign width          = active_q.width;
    assign height         = active_q.height;
    assign hsync_start    = active_q.hsync_start;
    assign hsync_end      = active_q.hsync_end;
    assign vsync_start    = active_q.vsync_start;
    assign vsync_end      = active_q.vsync_end;
    assign active_h_start = active_q.active_h_start;
    assign active_w_start = active_q.active_w_start;
    assign burst_len      = active_q.burst_len;
    assign wait_len       = active_q.wait_len;
endmodule

// File: tb/tb_dp_timing_ctrl.sv
// Directed-plus-random bench for dp_timing_ctrl against a register-level reference model.
module tb_dp_timing_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync_in;
    logic        gen_reset, busy;
    logic [15:0] width, height, hsync_start, hsync_end, vsync_start, vsync_end;
    logic [15:0] active_h_start, active_w_start;
    logic [7:0]  burst_len, wait_len;

    int checks = 0;
    int errors = 0;

    // Reference model: staged and active register words (addresses 1..5), frame count.
    logic [31:0] sreg [1:5];
    logic [31:0] act  [1:5];
    logic [31:0] fc;

    dp_timing_ctrl_if bus ();

    dp_timing_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .vsync_in       (vsync_in),
        .gen_reset      (gen_reset),
        .width          (width),
        .height         (height),
        .hsync_start    (hsync_start),
        .hsync_end      (hsync_end),
        .vsync_start    (vsync_start),
        .vsync_end      (vsync_end),
        .active_h_start (active_h_start),
        .active_w_start (active_w_start),
        .burst_len      (burst_len),
        .wait_len       (wait_len),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (a >= 3'd1 && a <= 3'd5) sreg[a] = (a == 3'd5) ? {16'h0, d[15:0]} : d;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.rd_en = 1'b1; bus.rd_addr = a;
        @(negedge clk);
        bus.rd_en = 1'b0;
        d = bus.rd_data;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0;
    endtask

    // Number of consecutive sampled cycles with gen_reset high, bounded.
    task automatic count_reset(output int n);
        n = 0;
        for (int i = 0; i < 20 && gen_reset; i++) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_active(input string tag);
        check({tag, "_size"}, {height, width}, act[1]);
        check({tag, "_hs"}, {hsync_end, hsync_start}, act[2]);
        check({tag, "_vs"}, {vsync_end, vsync_start}, act[3]);
        check({tag, "_act"}, {active_h_start, active_w_start}, act[4]);
        check({tag, "_burst"}, {16'h0, wait_len, burst_len}, act[5]);
    endtask

    function automatic bit staged_ok();
        int w, h, hs0, hs1, vs0, vs1, aw, ah, bl;
        w = sreg[1][15:0];  h = sreg[1][31:16];
        hs0 = sreg[2][15:0]; hs1 = sreg[2][31:16];
        vs0 = sreg[3][15:0]; vs1 = sreg[3][31:16];
        aw = sreg[4][15:0]; ah = sreg[4][31:16];
        bl = sreg[5][7:0];
        return w >= 2 && h >= 2 && aw < w && ah < h && bl != 0 && hs0 <= hs1 && vs0 <= vs1;
    endfunction

    initial begin
        int n, w, h, aw, ah, hs0, hs1, vs0, vs1, bl, wt, kind;
        int kinds [8] = '{0, 1, 0, 2, 3, 0, 4, 5};
        logic [31:0] d, nd;

        rst_n = 1'b0; vsync_in = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        sreg[1] = {16'd1125, 16'd2200};
        for (int i = 2; i <= 4; i++) sreg[i] = '0;
        sreg[5] = 32'd1;
        for (int i = 1; i <= 5; i++) act[i] = sreg[i];
        fc = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_gen_reset", gen_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check_active("rst");
        rd_check("rst_ctrl", 3'd0, 0);
        for (int i = 1; i <= 5; i++) rd_check("rst_reg", 3'(i), sreg[i]);
        rd_check("rst_status", 3'd6, 0);
        rd_check("rst_frame", 3'd7, 0);

        // Enable with commit: new size applied, ARM holds reset for four cycles
        wr(3'd1, {16'd525, 16'd800});
        wr(3'd0, 32'd3);
        for (int i = 1; i <= 5; i++) act[i] = sreg[i];
        check_active("en_commit");
        count_reset(n);
        check("en_reset_len", n, 4);
        rd_check("en_status_run", 3'd6, 2);
        rd_check("en_ctrl", 3'd0, 1);

        // Randomised commits from RUN, valid and with each invalid rule
        for (int it = 0; it < 8; it++) begin
            kind = kinds[it];
            w = $urandom_range(2, 4000); h = $urandom_range(2, 4000);
            aw = $urandom_range(0, w - 1); ah = $urandom_range(0, h - 1);
            hs0 = $urandom_range(0, 3000); hs1 = hs0 + $urandom_range(0, 500);
            vs0 = $urandom_range(0, 3000); vs1 = vs0 + $urandom_range(0, 500);
            bl = $urandom_range(1, 255); wt = $urandom_range(0, 255);
            case (kind)
                1: aw = w;
                2: bl = 0;
                3: hs0 = hs1 + 1;
                4: vs0 = vs1 + 1;
                5: begin h = 1; ah = 0; end
                default: ;
            endcase
            wr(3'd1, {16'(h), 16'(w)});
            wr(3'd2, {16'(hs1), 16'(hs0)});
            wr(3'd3, {16'(vs1), 16'(vs0)});
            wr(3'd4, {16'(ah), 16'(aw)});
            wr(3'd5, {16'hABCD, 8'(wt), 8'(bl)});
            wr(3'd0, 32'd3);
            if (staged_ok()) begin
                check("rnd_busy", busy, 1);
                check("rnd_genrst_wait", gen_reset, 0);
                rd_check("rnd_status_wait", 3'd6, 7);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                wr(3'd1, {16'(h), 16'(w + $urandom_range(0, 100))});
                check_active("rnd_hold");
                vsync_pulse();
                fc = fc + 1;
                for (int i = 1; i <= 5; i++) act[i] = sreg[i];
                check_active("rnd_apply");
                count_reset(n);
                check("rnd_reset_len", n, 4);
                check("rnd_busy_done", busy, 0);
            end else begin
                rd_check("rnd_status_err", 3'd6, 32'hA);
                check("rnd_busy_err", busy, 0);
                check_active("rnd_err_hold");
                wr(3'd0, 32'd5);
                rd_check("rnd_status_clr", 3'd6, 2);
            end
        end
        rd_check("rnd_frames", 3'd7, fc);

        // ENABLE cleared while waiting for a frame
        wr(3'd1, {16'd600, 16'd1000});
        wr(3'd2, {16'd20, 16'd10});
        wr(3'd3, {16'd6, 16'd2});
        wr(3'd4, {16'd40, 16'd100});
        wr(3'd5, 32'h0000_0304);
        wr(3'd0, 32'd3);
        check("wait_busy", busy, 1);
        wr(3'd0, 32'd0);
        check("off_gen_reset", gen_reset, 1);
        check("off_busy", busy, 0);
        rd_check("off_status", 3'd6, 0);
        check_active("off_hold");

        // Commit while OFF applies directly without pending
        wr(3'd1, {16'd480, 16'd640});
        wr(3'd0, 32'd2);
        for (int i = 1; i <= 5; i++) act[i] = sreg[i];
        check_active("off_commit");
        rd_check("off_commit_status", 3'd6, 0);

        wr(3'd0, 32'd1);
        count_reset(n);
        check("reen_reset_len", n, 4);

        // Frame counting and wrap
        repeat (3) vsync_pulse();
        fc = fc + 3;
        rd_check("frames_3", 3'd7, fc);
        wr(3'd7, 32'h1234_5678);
        rd_check("frame_ro", 3'd7, fc);
        @(negedge clk);
        force dut.frame_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.frame_count_q;
        vsync_pulse();
        rd_check("frame_max", 3'd7, 32'hFFFF_FFFF);
        vsync_pulse();
        rd_check("frame_wrap", 3'd7, 0);

        // Simultaneous write and read of one address returns the old value, then holds
        nd = $urandom;
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = nd;
        bus.rd_en = 1'b1; bus.rd_addr = 3'd2;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        check("rw_same_old", bus.rd_data, sreg[2]);
        sreg[2] = nd;
        rd(3'd2, d);
        check("rw_new", d, nd);
        repeat (3) @(negedge clk);
        check("rd_hold", bus.rd_data, nd);

        // Reset mid-operation
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sreg[1] = {16'd1125, 16'd2200};
        for (int i = 2; i <= 4; i++) sreg[i] = '0;
        sreg[5] = 32'd1;
        for (int i = 1; i <= 5; i++) act[i] = sreg[i];
        check("mid_rst_gen_reset", gen_reset, 1);
        check("mid_rst_rd_data", bus.rd_data, 0);
        check_active("mid_rst");
        rd_check("mid_rst_status", 3'd6, 0);
        rd_check("mid_rst_frame", 3'd7, 0);
        rd_check("mid_rst_hsync", 3'd2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
